// File: rtl/axis_hdr_insert_param_if.sv
// Stream bundle for the header inserter: payload in, header in, merged stream out.
interface axis_hdr_insert_param_if #(
    parameter int unsigned DATA_WD = 32
) ();
    localparam int unsigned BYTE_NUM = DATA_WD / 8;
    localparam int unsigned BCNT_WD  = $clog2(BYTE_NUM);

    // payload stream
    logic                valid_in;
    logic                ready_in;
    logic [DATA_WD-1:0]  data_in;
    logic [BYTE_NUM-1:0] keep_in;
    logic                last_in;

    // header
    logic                valid_insert;
    logic                ready_insert;
    logic [DATA_WD-1:0]  data_insert;
    logic [BYTE_NUM-1:0] keep_insert;
    logic [BCNT_WD-1:0]  byte_insert_cnt;

    // merged output stream
    logic                valid_out;
    logic                ready_out;
    logic [DATA_WD-1:0]  data_out;
    logic [BYTE_NUM-1:0] keep_out;
    logic                last_out;

    // block side
    modport slave (
        input  valid_in, data_in, keep_in, last_in,
        input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
        input  ready_out,
        output ready_in, ready_insert,
        output valid_out, data_out, keep_out, last_out
    );

    // source / sink side
    modport master (
        output valid_in, data_in, keep_in, last_in,
        output valid_insert, data_insert, keep_insert, byte_insert_cnt,
        output ready_out,
        input  ready_in, ready_insert,
        input  valid_out, data_out, keep_out, last_out
    );
endinterface

// File: rtl/axis_hdr_insert_param.sv
// Prepends a variable-length (1..BYTE_NUM bytes) header to an AXI-stream packet,
// re-aligning the payload behind it and emitting a trailing beat when needed.
module axis_hdr_insert_param #(
    parameter int unsigned DATA_WD = 32,
    parameter int unsigned CNT_WD  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    axis_hdr_insert_param_if.slave bus,
    output logic [CNT_WD-1:0]      pkt_cnt
);
    localparam int unsigned BYTE_NUM = DATA_WD / 8;
    localparam int unsigned BCNT_WD  = $clog2(BYTE_NUM);
    // byte counts up to 2*BYTE_NUM need two extra bits over the header count
    localparam int unsigned LEN_WD   = BCNT_WD + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        TAIL   = 2'd2
    } state_e;

    state_e               state_q,     state_d;
    logic                 valid_out_q, valid_out_d;
    logic [DATA_WD-1:0]   data_out_q,  data_out_d;
    logic [BYTE_NUM-1:0]  keep_out_q,  keep_out_d;
    logic                 last_out_q,  last_out_d;
    logic [DATA_WD-1:0]   resid_q,     resid_d;
    logic [LEN_WD-1:0]    hdr_len_q,   hdr_len_d;
    logic [LEN_WD-1:0]    tail_len_q,  tail_len_d;
    logic [CNT_WD-1:0]    pkt_cnt_q,   pkt_cnt_d;

    logic                 out_free_c;
    logic                 ready_in_c;
    logic                 ready_insert_c;
    logic [LEN_WD-1:0]    in_len_c;
    logic [LEN_WD-1:0]    room_c;
    logic [2*DATA_WD-1:0] joined_c;
    logic [DATA_WD-1:0]   merged_c;
    logic [DATA_WD-1:0]   tail_data_c;
    logic                 unused_keep_insert;

    // Number of set bits in a keep vector (keep is contiguous, so this is the byte count).
    function automatic logic [LEN_WD-1:0] count_keep(input logic [BYTE_NUM-1:0] keep);
        logic [BYTE_NUM-1:0] k;
        logic [LEN_WD-1:0]   n;
        k = keep;
        n = '0;
        for (int unsigned i = 0; i < BYTE_NUM; i++) begin
            n = n + LEN_WD'(k[0]);
            k = k >> 1;
        end
        return n;
    endfunction

    // Keep vector with the top m bytes valid (m <= BYTE_NUM).
    function automatic logic [BYTE_NUM-1:0] top_mask(input logic [LEN_WD-1:0] m);
        return ~({BYTE_NUM{1'b1}} >> m);
    endfunction

    // Header keep is informational only.
    assign unused_keep_insert = ^bus.keep_insert;

    // Datapath helpers: payload bytes per beat, alignment shifts.
    always_comb begin
        out_free_c  = !valid_out_q || bus.ready_out;
        in_len_c    = count_keep(bus.keep_in);
        room_c      = LEN_WD'(BYTE_NUM) - hdr_len_q;
        joined_c    = {resid_q, bus.data_in};
        merged_c    = DATA_WD'(joined_c >> {hdr_len_q, 3'b000});
        tail_data_c = resid_q << {room_c, 3'b000};
    end

    // State register and output/datapath flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            keep_out_q  <= '0;
            last_out_q  <= 1'b0;
            resid_q     <= '0;
            hdr_len_q   <= '0;
            tail_len_q  <= '0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            keep_out_q  <= keep_out_d;
            last_out_q  <= last_out_d;
            resid_q     <= resid_d;
            hdr_len_q   <= hdr_len_d;
            tail_len_q  <= tail_len_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    // Next-state, output register load and handshake readies.
    always_comb begin
        state_d        = state_q;
        valid_out_d    = valid_out_q && !bus.ready_out;
        data_out_d     = data_out_q;
        keep_out_d     = keep_out_q;
        last_out_d     = last_out_q;
        resid_d        = resid_q;
        hdr_len_d      = hdr_len_q;
        tail_len_d     = tail_len_q;
        pkt_cnt_d      = pkt_cnt_q + CNT_WD'(valid_out_q && bus.ready_out && last_out_q);
        ready_in_c     = 1'b0;
        ready_insert_c = 1'b0;

        case (state_q)
            IDLE: begin
                // header may be taken while the previous last beat still waits
                ready_insert_c = 1'b1;
                if (bus.valid_insert) begin
                    resid_d   = bus.data_insert;
                    hdr_len_d = LEN_WD'(bus.byte_insert_cnt) + LEN_WD'(1);
                    state_d   = STREAM;
                end
            end

            STREAM: begin
                ready_in_c = out_free_c;
                if (bus.valid_in && out_free_c) begin
                    valid_out_d = 1'b1;
                    data_out_d  = merged_c;
                    keep_out_d  = '1;
                    last_out_d  = 1'b0;
                    resid_d     = bus.data_in;
                    if (bus.last_in) begin
                        if (in_len_c <= room_c) begin
                            keep_out_d = top_mask(hdr_len_q + in_len_c);
                            last_out_d = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            // leftover bytes sit in the residual; flush them next
                            tail_len_d = in_len_c - room_c;
                            state_d    = TAIL;
                        end
                    end
                end
            end

            TAIL: begin
                if (out_free_c) begin
                    valid_out_d = 1'b1;
                    data_out_d  = tail_data_c;
                    keep_out_d  = top_mask(tail_len_q);
                    last_out_d  = 1'b1;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Port drive; readies are forced low while reset is held.
    assign bus.ready_in     = ready_in_c;
    assign bus.ready_insert = ready_insert_c && !rst;
    assign bus.valid_out    = valid_out_q;
    assign bus.data_out     = data_out_q;
    assign bus.keep_out     = keep_out_q;
    assign bus.last_out     = last_out_q;
    assign pkt_cnt          = pkt_cnt_q;

endmodule
